// File: rtl/ser_pkg.sv
// Shared types and helpers for the serial receive and transmit blocks.
package ser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam int         SER_BITS = 8;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int div_calc(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/ser_baud_tick.sv
// Oversample tick generator: one-clock o_tick every DIV clocks, restartable.
module ser_baud_tick #(
    parameter int DIV   = 10,
    parameter int DIV_W = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/ser_rcv_unit.sv
// Oversampling async serial receiver (8N1; 8E1/8O1 when SER_RCV_PARITY_EN is defined).
// Each good byte lands on char_in with a one-clock rcv_done; error flags are sticky.
module ser_rcv_unit
    import ser_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       rx_en,
    input  logic       clr_err,
    output logic [7:0] char_in,
    output logic       rcv_done,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output rx_state_t  o_dbg_state
);

    localparam int              DIV       = div_calc(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int              DIV_W     = $clog2(DIV);
    localparam int              TC_W      = $clog2(OVERSAMPLE);
    localparam logic [TC_W-1:0] HALF_LAST = TC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TC_W-1:0] FULL_LAST = TC_W'(OVERSAMPLE - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(SER_BITS - 1);

    logic            r_sync1, r_rxd_s;
    rx_state_t       r_state, w_next;
    logic            w_tick, w_start_det, w_bit_end;
    logic [TC_W-1:0] r_tcnt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift, r_char;
    logic            r_done, r_ferr, r_bad, r_armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxd_s <= r_sync1;
        end
    end

    // Start detection lands on a tick, so the baud counter restart keeps tick phase.
    ser_baud_tick #(.DIV(DIV), .DIV_W(DIV_W)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_start_det),
        .o_tick    (w_tick)
    );

    // The detection tick counts as the first start-bit tick, centring the samples.
    assign w_start_det = (r_state == IDLE) && rx_en && r_armed && w_tick && !r_rxd_s;
    assign w_bit_end   = rx_en && w_tick &&
                         (r_tcnt == ((r_state == START) ? HALF_LAST : FULL_LAST));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_start_det) w_next = START;
            START: if (w_bit_end) w_next = r_rxd_s ? IDLE : DATA;
`ifdef SER_RCV_PARITY_EN
            DATA:   if (w_bit_end && r_bitcnt == BIT_LAST) w_next = PARITY;
            PARITY: if (w_bit_end) w_next = STOP;
`else
            DATA:  if (w_bit_end && r_bitcnt == BIT_LAST) w_next = STOP;
`endif
            STOP:  if (w_bit_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (!rx_en) w_next = IDLE;
    end

`ifdef SER_RCV_PARITY_EN
    logic r_perr;
    logic w_par_bad;
    assign w_par_bad = ((^r_shift) ^ r_rxd_s) != PARITY_ODD;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tcnt   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_char   <= '0;
            r_done   <= 1'b0;
            r_ferr   <= 1'b0;
            r_bad    <= 1'b0;
            r_armed  <= 1'b0;
`ifdef SER_RCV_PARITY_EN
            r_perr   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (clr_err) begin
                r_ferr <= 1'b0;
`ifdef SER_RCV_PARITY_EN
                r_perr <= 1'b0;
`endif
            end
            // Arming needs a high line seen after (re-)entering IDLE.
            if (r_state != IDLE) r_armed <= 1'b0;
            else if (r_rxd_s)    r_armed <= 1'b1;

            if (w_start_det) begin
                r_tcnt   <= TC_W'(1);
                r_bitcnt <= '0;
                r_bad    <= 1'b0;
            end else if (r_state != IDLE && w_tick) begin
                r_tcnt <= w_bit_end ? '0 : r_tcnt + 1'b1;
            end

            if (w_bit_end && r_state == DATA) begin
                r_shift  <= {r_rxd_s, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
`ifdef SER_RCV_PARITY_EN
            if (w_bit_end && r_state == PARITY && w_par_bad) begin
                r_perr <= 1'b1;
                r_bad  <= 1'b1;
            end
`endif
            if (w_bit_end && r_state == STOP) begin
                if (!r_rxd_s) begin
                    r_ferr <= 1'b1;
                end else if (!r_bad) begin
                    r_char <= r_shift;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign char_in     = r_char;
    assign rcv_done    = r_done;
    assign busy        = (r_state != IDLE);
    assign frame_err   = r_ferr;
    assign o_dbg_state = r_state;

`ifdef SER_RCV_PARITY_EN
    assign parity_err = r_perr;
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
    assign parity_err          = 1'b0;
`endif

endmodule

// File: tb/tb_ser_rcv_unit.sv
// Directed bench for ser_rcv_unit at DIV=10 (160 clk per bit), with a character scoreboard.
module tb_ser_rcv_unit;
    import ser_pkg::*;

    localparam int BIT_CLKS = 160;
`ifdef SER_RCV_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int EXTRA  = PAR_EN ? BIT_CLKS : 0;
    localparam int LAT_LO = 1510 + EXTRA;
    localparam int LAT_HI = 1530 + EXTRA;

    logic       clk = 1'b0;
    logic       rst_n, rxd, rx_en, clr_err;
    logic [7:0] char_in;
    logic       rcv_done, busy, frame_err, parity_err;
    rx_state_t  dbg_state;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         n0, t2_start;
    int         done_cyc[$];
    logic [7:0] exp_q[$];
    logic       prev_done = 1'b0;
    logic       busy_seen = 1'b0;

    ser_rcv_unit #(
        .CLK_FREQ_HZ (1_600_000),
        .BAUD        (10_000),
        .OVERSAMPLE  (16),
        .PARITY_ODD  (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .rx_en       (rx_en),
        .clr_err     (clr_err),
        .char_in     (char_in),
        .rcv_done    (rcv_done),
        .busy        (busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .o_dbg_state (dbg_state)
    );

    // clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // scoreboard: every rcv_done must match the next expected byte and last one clock
    always @(negedge clk) begin
        if (rcv_done) begin
            done_cyc.push_back(cyc);
            chk("done_width", {31'b0, prev_done}, 32'd0);
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_done: observed char %0h expected no rcv_done", char_in);
            end
            if (exp_q.size() != 0) chk("char_at_done", char_in, exp_q.pop_front());
        end
        if (busy) busy_seen = 1'b1;
        prev_done = rcv_done;
    end

    // driver tasks (called on a negedge)
    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit((^d) ^ par_flip);
        drive_bit(stop_b);
        rxd = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rx_en = 1'b0; rxd = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_char", char_in, 8'h00);
        chk("rst_done", rcv_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1; rx_en = 1'b1;
        repeat (20) @(negedge clk);

        // single byte, latency
        n0 = done_cyc.size();
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t1_count", done_cyc.size() - n0, 1);
        if (done_cyc.size() > n0) chk_range("t1_latency", done_cyc[n0] - start_cyc, LAT_LO, LAT_HI);
        chk("t1_char", char_in, 8'h41);
        chk("t1_busy_after", busy, 0);

        // back-to-back frames, no idle gap
        n0 = done_cyc.size();
        exp_q.push_back(8'h55);
        exp_q.push_back(ASCII_CR);
        send_frame(8'h55, 1'b1, 1'b0);
        t2_start = start_cyc;
        send_frame(8'h0D, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t2_count", done_cyc.size() - n0, 2);
        if (done_cyc.size() > n0 + 1)
            chk_range("t2_gap", done_cyc[n0 + 1] - done_cyc[n0], BIT_CLKS * 10 - 10 + EXTRA, BIT_CLKS * 10 + 10 + EXTRA);
        chk("t2_char", char_in, 8'h0D);
        chk("t2_exp_empty", exp_q.size(), 0);

        // 30-clk glitch on idle line
        n0 = done_cyc.size();
        busy_seen = 1'b0;
        rxd = 1'b0;
        repeat (30) @(negedge clk);
        rxd = 1'b1;
        repeat (90) @(negedge clk);
        chk("t3_busy_seen", busy_seen, 1);
        chk("t3_busy_low", busy, 0);
        chk("t3_count", done_cyc.size() - n0, 0);
        chk("t3_ferr", frame_err, 0);
        chk("t3_perr", parity_err, 0);

        // framing error, then clear
        n0 = done_cyc.size();
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("t4_ferr_set", frame_err, 1);
        chk("t4_count", done_cyc.size() - n0, 0);
        chk("t4_char_kept", char_in, 8'h0D);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("t4_ferr_clr", frame_err, 0);

        // rx_en abort mid-frame
        n0 = done_cyc.size();
        rxd = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("ab_busy_mid", busy, 1);
        rx_en = 1'b0;
        rxd = 1'b1;
        @(negedge clk);
        chk("ab_busy_off", busy, 0);
        chk("ab_state", 32'(dbg_state), 32'(IDLE));
        rx_en = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("ab_count", done_cyc.size() - n0, 0);
        chk("ab_ferr", frame_err, 0);

        // reset mid-byte
        rxd = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        chk("t5_busy_mid", busy, 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_char", char_in, 8'h00);
        chk("t5_done", rcv_done, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ferr", frame_err, 0);
        chk("t5_perr", parity_err, 0);
        rst_n = 1'b1;
        rxd = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        n0 = done_cyc.size();
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_count", done_cyc.size() - n0, 1);
        chk("t5_char_rx", char_in, 8'h3C);

`ifdef SER_RCV_PARITY_EN
        // even parity: bad parity bit then good
        n0 = done_cyc.size();
        send_frame(8'h03, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk("t6_perr_set", parity_err, 1);
        chk("t6_count_bad", done_cyc.size() - n0, 0);
        chk("t6_char_kept", char_in, 8'h3C);
        chk("t6_ferr", frame_err, 0);
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t6_count_good", done_cyc.size() - n0, 1);
        chk("t6_char", char_in, 8'h03);
        chk("t6_perr_sticky", parity_err, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("t6_perr_clr", parity_err, 0);
`else
        chk("parity_tied", parity_err, 0);
`endif

        chk("final_exp_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
